rect_drag_drop_ctl: RTL and testbench

Position controller for the on-screen rectangle: grabs the rectangle when the left mouse button is pressed over it, drags it with the cursor, and on release drops it under constant gravity with optional floor bounce. Sits between the mouse interface (position/button) and the rectangle drawing stage, which consumes `xpos`/`ypos` as the rectangle's top-left corner. All motion updates are frame-paced by a one-cycle `frame_tick` so the drawn image never tears mid-frame.

---
 rtl/rect_drag_drop_ctl.sv | 138 +++++++++++++
 tb/tb_rect_drag_drop_ctl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rect_drag_drop_ctl.sv
// rect_drag_drop_ctl: grab/drag/drop position controller for the on-screen rectangle.
// Optional floor bounce is enabled by defining RECT_BOUNCE_EN; otherwise the rectangle lands and stops.
module rect_drag_drop_ctl #(
    parameter int RECT_W       = 48,
    parameter int RECT_H       = 64,
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int START_X      = 100,
    parameter int START_Y      = 100,
    parameter int GRAVITY      = 1,
    parameter int VMAX         = 31,
    parameter int BOUNCE_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        frame_tick,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {IDLE = 2'd0, GRAB = 2'd1, FALL = 2'd2} state_t;

`ifdef RECT_BOUNCE_EN
    localparam bit BOUNCE_EN = 1'b1;
`else
    localparam bit BOUNCE_EN = 1'b0;
`endif

    localparam logic signed [13:0] FLOOR_S = 14'(SCREEN_H - RECT_H);
    localparam logic signed [12:0] XMAX_S  = 13'(SCREEN_W - RECT_W);
    localparam logic signed [12:0] YMAX_S  = 13'(SCREEN_H - RECT_H);
    localparam logic signed [8:0]  VMAX_S  = 9'(VMAX);
    localparam logic signed [8:0]  GRAV_S  = 9'(GRAVITY);

    state_t             state_q, state_d;
    logic [11:0]        xpos_q, xpos_d, ypos_q, ypos_d;
    logic [11:0]        dx_q, dx_d, dy_q, dy_d;
    logic signed [7:0]  vel_q, vel_d;
    logic               left_prev_q;

    logic               press, hit;
    logic signed [12:0] gx, gy;
    logic [11:0]        drag_x, drag_y;
    logic signed [8:0]  vsum;
    logic signed [7:0]  vnew, vbounce;
    logic signed [13:0] fall_y;

    assign press  = mouse_left && !left_prev_q;
    assign hit    = (mouse_xpos >= xpos_q) && (13'(mouse_xpos) < 13'(xpos_q) + 13'(RECT_W)) &&
                    (mouse_ypos >= ypos_q) && (13'(mouse_ypos) < 13'(ypos_q) + 13'(RECT_H));
    assign gx     = $signed({1'b0, mouse_xpos}) - $signed({1'b0, dx_q});
    assign gy     = $signed({1'b0, mouse_ypos}) - $signed({1'b0, dy_q});
    assign drag_x = gx < 0 ? 12'd0 : gx > XMAX_S ? XMAX_S[11:0] : gx[11:0];
    assign drag_y = gy < 0 ? 12'd0 : gy > YMAX_S ? YMAX_S[11:0] : gy[11:0];
    assign vsum   = 9'(vel_q) + GRAV_S;
    assign vnew   = vsum > VMAX_S ? VMAX_S[7:0] : vsum[7:0];
    assign fall_y = $signed({2'b00, ypos_q}) + 14'(vnew);
    assign vbounce = vnew >>> BOUNCE_SHIFT;

    assign xpos  = xpos_q;
    assign ypos  = ypos_q;
    assign state = state_q;

    // Next-state: grab on press over the rectangle, drag on ticks, fall under gravity after release.
    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        ypos_d  = ypos_q;
        vel_d   = vel_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        case (state_q)
            IDLE: begin
                if (press && hit) begin
                    state_d = GRAB;
                    dx_d    = mouse_xpos - xpos_q;
                    dy_d    = mouse_ypos - ypos_q;
                end
            end
            GRAB: begin
                if (!mouse_left) begin
                    state_d = FALL;
                    vel_d   = '0;
                end else if (frame_tick) begin
                    xpos_d = drag_x;
                    ypos_d = drag_y;
                end
            end
            FALL: begin
                if (press && hit) begin
                    state_d = GRAB;
                    dx_d    = mouse_xpos - xpos_q;
                    dy_d    = mouse_ypos - ypos_q;
                    vel_d   = '0;
                end else if (frame_tick) begin
                    if (fall_y < 0) begin
                        ypos_d = '0;
                        vel_d  = '0;
                    end else if (fall_y >= FLOOR_S) begin
                        ypos_d  = FLOOR_S[11:0];
                        vel_d   = (BOUNCE_EN && vbounce != 0) ? -vbounce : 8'sd0;
                        state_d = (BOUNCE_EN && vbounce != 0) ? FALL : IDLE;
                    end else begin
                        ypos_d = fall_y[11:0];
                        vel_d  = vnew;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; previous-button resets high so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            xpos_q      <= 12'(START_X);
            ypos_q      <= 12'(START_Y);
            vel_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            left_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            xpos_q      <= xpos_d;
            ypos_q      <= ypos_d;
            vel_q       <= vel_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            left_prev_q <= mouse_left;
        end
    end

endmodule

// File: tb/tb_rect_drag_drop_ctl.sv
// tb_rect_drag_drop_ctl: directed self-checking bench for rect_drag_drop_ctl.
module tb_rect_drag_drop_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] mouse_xpos = 12'd0;
    logic [11:0] mouse_ypos = 12'd0;
    logic        mouse_left = 1'b1;
    logic        frame_tick = 1'b0;
    logic [11:0] xpos, ypos;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    rect_drag_drop_ctl dut (
        .clk(clk), .rst(rst),
        .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left), .frame_tick(frame_tick),
        .xpos(xpos), .ypos(ypos), .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        mouse_xpos = 12'd110;
        mouse_ypos = 12'd120;
        mouse_left = 1'b1;
        rst = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd0, 12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL reset_hold: got st=%0d x=%0d y=%0d want st=0 x=100 y=100", state, xpos, ypos);
        end
        rst = 1'b1;
        step();
        tick();
        step();
        tick();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd0, 12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL held_button_no_grab: got st=%0d x=%0d y=%0d want st=0 x=100 y=100", state, xpos, ypos);
        end
    endtask

    task automatic test_press_miss();
        mouse_left = 1'b0; step();
        mouse_xpos = 12'd10; mouse_ypos = 12'd10; mouse_left = 1'b1; step();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd0, 12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL miss_far: got st=%0d x=%0d y=%0d want st=0 x=100 y=100", state, xpos, ypos);
        end
        mouse_left = 1'b0; step();
        mouse_xpos = 12'd148; mouse_ypos = 12'd120; mouse_left = 1'b1; step();
        n_cmp++;
        if (state !== 2'd0) begin
            n_bad++;
            $display("FAIL miss_right_edge: got st=%0d want st=0", state);
        end
        mouse_left = 1'b0; step();
    endtask

    task automatic test_drag();
        mouse_xpos = 12'd110; mouse_ypos = 12'd120; mouse_left = 1'b1; step();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd1, 12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL grab: got st=%0d x=%0d y=%0d want st=1 x=100 y=100", state, xpos, ypos);
        end
        mouse_xpos = 12'd300; mouse_ypos = 12'd200; step();
        n_cmp++;
        if ({xpos, ypos} !== {12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL drag_waits_tick: got x=%0d y=%0d want x=100 y=100", xpos, ypos);
        end
        tick();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd1, 12'd290, 12'd180}) begin
            n_bad++;
            $display("FAIL drag_move: got st=%0d x=%0d y=%0d want st=1 x=290 y=180", state, xpos, ypos);
        end
        mouse_xpos = 12'd5; mouse_ypos = 12'd5; tick();
        n_cmp++;
        if ({xpos, ypos} !== {12'd0, 12'd0}) begin
            n_bad++;
            $display("FAIL clamp_low: got x=%0d y=%0d want x=0 y=0", xpos, ypos);
        end
        mouse_xpos = 12'd1000; mouse_ypos = 12'd1000; tick();
        n_cmp++;
        if ({xpos, ypos} !== {12'd752, 12'd536}) begin
            n_bad++;
            $display("FAIL clamp_high: got x=%0d y=%0d want x=752 y=536", xpos, ypos);
        end
        mouse_xpos = 12'd300; mouse_ypos = 12'd200; tick();
    endtask

    task automatic test_fall();
        mouse_left = 1'b0; step();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd2, 12'd290, 12'd180}) begin
            n_bad++;
            $display("FAIL release: got st=%0d x=%0d y=%0d want st=2 x=290 y=180", state, xpos, ypos);
        end
        tick();
        n_cmp++;
        if (ypos !== 12'd181) begin n_bad++; $display("FAIL fall1: got y=%0d want y=181", ypos); end
        tick();
        n_cmp++;
        if (ypos !== 12'd183) begin n_bad++; $display("FAIL fall2: got y=%0d want y=183", ypos); end
        tick();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd2, 12'd290, 12'd186}) begin
            n_bad++;
            $display("FAIL fall3: got st=%0d x=%0d y=%0d want st=2 x=290 y=186", state, xpos, ypos);
        end
    endtask

    task automatic test_catch();
        mouse_xpos = 12'd300; mouse_ypos = 12'd200; mouse_left = 1'b1; tick();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd1, 12'd290, 12'd186}) begin
            n_bad++;
            $display("FAIL catch_on_tick: got st=%0d x=%0d y=%0d want st=1 x=290 y=186", state, xpos, ypos);
        end
        mouse_ypos = 12'd64; tick();
        n_cmp++;
        if ({xpos, ypos} !== {12'd290, 12'd50}) begin
            n_bad++;
            $display("FAIL catch_offset: got x=%0d y=%0d want x=290 y=50", xpos, ypos);
        end
    endtask

    task automatic test_floor();
        mouse_left = 1'b0; step();
        repeat (30) tick();
        n_cmp++;
        if ({state, ypos} !== {2'd2, 12'd515}) begin
            n_bad++;
            $display("FAIL pre_impact: got st=%0d y=%0d want st=2 y=515", state, ypos);
        end
        tick();
`ifdef RECT_BOUNCE_EN
        n_cmp++;
        if ({state, ypos} !== {2'd2, 12'd536}) begin
            n_bad++;
            $display("FAIL impact_bounce: got st=%0d y=%0d want st=2 y=536", state, ypos);
        end
        tick();
        n_cmp++;
        if (ypos !== 12'd522) begin n_bad++; $display("FAIL rebound: got y=%0d want y=522", ypos); end
        for (int i = 0; i < 300 && state != 2'd0; i++) tick();
        n_cmp++;
        if ({state, ypos} !== {2'd0, 12'd536}) begin
            n_bad++;
            $display("FAIL settle: got st=%0d y=%0d want st=0 y=536", state, ypos);
        end
`else
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd0, 12'd290, 12'd536}) begin
            n_bad++;
            $display("FAIL impact_land: got st=%0d x=%0d y=%0d want st=0 x=290 y=536", state, xpos, ypos);
        end
        tick();
        n_cmp++;
        if ({state, ypos} !== {2'd0, 12'd536}) begin
            n_bad++;
            $display("FAIL landed_hold: got st=%0d y=%0d want st=0 y=536", state, ypos);
        end
`endif
    endtask

    task automatic test_async_reset();
        mouse_xpos = 12'd300; mouse_ypos = 12'd540; mouse_left = 1'b1; step();
        mouse_left = 1'b0; step();
        n_cmp++;
        if (state !== 2'd2) begin n_bad++; $display("FAIL regrab_fall: got st=%0d want st=2", state); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd0, 12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL async_reset: got st=%0d x=%0d y=%0d want st=0 x=100 y=100", state, xpos, ypos);
        end
        step();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({state, xpos, ypos} !== {2'd0, 12'd100, 12'd100}) begin
            n_bad++;
            $display("FAIL post_reset: got st=%0d x=%0d y=%0d want st=0 x=100 y=100", state, xpos, ypos);
        end
    endtask

    initial begin
        test_reset();
        test_press_miss();
        test_drag();
        test_fall();
        test_catch();
        test_floor();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
